// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// imem_boot_loader: streams a length-prefixed byte image into instruction RAM,
// then hands the RAM read port to the CPU. Optional macro: IMEM_CSUM_EN. Rev 1.0
// ============================================================================
module imem_boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    input  logic              load_start_i,
    input  logic [31:0]       cpu_addr_i,
    output logic [31:0]       cpu_instr_o,
    output logic              cpu_hold_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_we_o,
    input  logic [31:0]       mem_rdata_i,
    output logic              load_done_o,
    output logic              load_err_o
);

`ifdef IMEM_CSUM_EN
    typedef enum logic [2:0] {
        S_LEN_HI = 3'd0,
        S_LEN_LO = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_RUN    = 3'd4
    } state_t;
    localparam state_t c_AFTER_DATA = S_CSUM;
`else
    typedef enum logic [2:0] {
        S_LEN_HI = 3'd0,
        S_LEN_LO = 3'd1,
        S_DATA   = 3'd2,
        S_RUN    = 3'd4
    } state_t;
    localparam state_t c_AFTER_DATA = S_RUN;
`endif

    localparam logic [15:0]       c_MAX_IDX   = 16'(MAX_WORDS);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(MAX_WORDS - 1);

    state_t      state_q;
    logic [15:0] n_q;
    logic [15:0] idx_q;
    logic [1:0]  bcnt_q;
    logic [23:0] shift_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        wdone_q;
    logic        pend_q;
    logic        err_q;
`ifdef IMEM_CSUM_EN
    logic [7:0]  csum_q;
`endif

    logic              w_run;
    logic              w_xfer;
    logic              w_ovf;
    logic              w_last;
    logic [ADDR_W-1:0] w_idx_addr;
    logic              unused_addr_bits;

    assign w_run  = (state_q == S_RUN);
    // pend_q marks the single drain cycle after the final word, so no byte is taken then
    assign rx_ready_o = !w_run && !pend_q;
    assign w_xfer = rx_valid_i && rx_ready_o;
    assign w_ovf  = (idx_q >= c_MAX_IDX);
    assign w_last = (({1'b0, idx_q} + 17'd1) == {1'b0, n_q});
    // Overflow words park the address at the top entry instead of wrapping to 0
    assign w_idx_addr = w_ovf ? c_LAST_ADDR : idx_q[ADDR_W-1:0];

    assign cpu_hold_o  = !w_run;
    assign load_done_o = w_run;
    assign load_err_o  = err_q;
    assign mem_we_o    = we_q;
    assign mem_wdata_o = wdata_q;
    assign mem_addr_o  = w_run ? cpu_addr_i[ADDR_W+1:2] : w_idx_addr;
    assign cpu_instr_o = w_run ? mem_rdata_i : 32'h0;
    assign unused_addr_bits = ^{cpu_addr_i[31:ADDR_W+2], cpu_addr_i[1:0]};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_LEN_HI;
            n_q     <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            shift_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            wdone_q <= 1'b0;
            pend_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            we_q    <= 1'b0;
            wdone_q <= 1'b0;
            if (wdone_q) begin
                idx_q <= idx_q + 16'd1;
            end
            case (state_q)
                S_LEN_HI: begin
                    if (w_xfer) begin
                        n_q[15:8] <= rx_data_i;
                        state_q   <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (w_xfer) begin
                        n_q[7:0] <= rx_data_i;
                        state_q  <= S_DATA;
                        if ({n_q[15:8], rx_data_i} == 16'd0) begin
                            pend_q <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (pend_q) begin
                        pend_q  <= 1'b0;
                        state_q <= c_AFTER_DATA;
                    end else if (w_xfer) begin
                        bcnt_q <= bcnt_q + 2'd1;
`ifdef IMEM_CSUM_EN
                        csum_q <= csum_q ^ rx_data_i;
`endif
                        if (bcnt_q == 2'd3) begin
                            wdata_q <= {shift_q, rx_data_i};
                            wdone_q <= 1'b1;
                            we_q    <= !w_ovf;
                            if (w_ovf) begin
                                err_q <= 1'b1;
                            end
                            if (w_last) begin
                                pend_q <= 1'b1;
                            end
                        end else begin
                            shift_q <= {shift_q[15:0], rx_data_i};
                        end
                    end
                end
`ifdef IMEM_CSUM_EN
                S_CSUM: begin
                    if (w_xfer) begin
                        if (rx_data_i == csum_q) begin
                            state_q <= S_RUN;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= S_LEN_HI;
                            n_q     <= '0;
                            idx_q   <= '0;
                            bcnt_q  <= '0;
                            shift_q <= '0;
                            pend_q  <= 1'b0;
                            csum_q  <= '0;
                        end
                    end
                end
`endif
                S_RUN: begin
                    if (load_start_i) begin
                        state_q <= S_LEN_HI;
                        err_q   <= 1'b0;
                        n_q     <= '0;
                        idx_q   <= '0;
                        bcnt_q  <= '0;
                        shift_q <= '0;
                        pend_q  <= 1'b0;
`ifdef IMEM_CSUM_EN
                        csum_q  <= '0;
`endif
                    end
                end
                default: begin
                    state_q <= S_LEN_HI;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
